// File: rtl/max_pool_2x2_pkg.sv
// ---------------------------------------------------------------------------
// max_pool_2x2_pkg
// Shared definitions for the 2x2 / stride-2 max-pooling stage:
//   - pool_state_t : FSM state encoding (IDLE, RUN, DONE)
//   - DEFAULT_DATA_WIDTH : default pixel width
//   - signed_max   : two's-complement maximum of two sign-extended operands
// No ports (package).
// ---------------------------------------------------------------------------
package max_pool_2x2_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  // Operands are sign-extended to this width before comparison, so any
  // DATA_WIDTH up to 64 bits can share the single max function below.
  localparam int MAX_CALC_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pool_state_t;

  function automatic logic signed [MAX_CALC_WIDTH-1:0] signed_max(
    input logic signed [MAX_CALC_WIDTH-1:0] a,
    input logic signed [MAX_CALC_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_fifo.sv
// ---------------------------------------------------------------------------
// pool_line_fifo
// Line buffer that parks the horizontal pair maxima of an even row until
// the matching pairs of the following odd row arrive.
// DEPTH entries of DATA_WIDTH bits, registered write, combinational head.
// Pointers wrap after DEPTH-1 by explicit compare (DEPTH need not be a
// power of two).
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (clears pointers)
//   clr      in   synchronous pointer clear at the start of a map
//   wr_en    in   write wr_data at wr_ptr, advance wr_ptr
//   wr_data  in   DATA_WIDTH pair maximum to park
//   rd_en    in   advance rd_ptr (head consumed this cycle)
//   rd_data  out  DATA_WIDTH entry at rd_ptr (combinational)
// ---------------------------------------------------------------------------
module pool_line_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 10,
  parameter int ADD_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam logic [ADD_WIDTH-1:0] PTR_LAST = ADD_WIDTH'(DEPTH - 1);

  // Sized to the full pointer range so every pointer value is a legal index;
  // only the first DEPTH entries are ever written.
  logic [DATA_WIDTH-1:0] mem [2**ADD_WIDTH];
  logic [ADD_WIDTH-1:0]  wr_ptr;
  logic [ADD_WIDTH-1:0]  rd_ptr;

  // Storage has no reset: contents are always written before being read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + ADD_WIDTH'(1);
      end
      if (rd_en) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + ADD_WIDTH'(1);
      end
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/max_pool_2x2.sv
// ---------------------------------------------------------------------------
// max_pool_2x2
// Streaming 2x2, stride-2 max pooling of a raster-ordered signed feature map.
// Even columns are parked in a hold register; on odd columns the pair
// maximum is either parked in the line buffer (even rows) or combined with
// the parked maximum from the row above to form a pooled pixel (odd rows).
// Optional feature macro: POOL_RELU_EN -- when defined, negative pooled
// results are clamped to 0 at the output register.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begins a feature map (honoured in IDLE only)
//   in_valid   in   in_data carries the next raster pixel (RUN only)
//   in_data    in   DATA_WIDTH signed pixel
//   out_valid  out  registered, pooled pixel present
//   out_data   out  DATA_WIDTH signed pooled pixel, 0 when out_valid is low
//   busy       out  high in RUN and DONE
//   done       out  one-cycle pulse in the DONE state
// ---------------------------------------------------------------------------
module max_pool_2x2
  import max_pool_2x2_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int IFM_WIDTH  = 20,
  parameter int IFM_HEIGHT = 20,
  parameter int ADD_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
);

  localparam int COL_W = $clog2(IFM_WIDTH);
  localparam int ROW_W = $clog2(IFM_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IFM_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IFM_HEIGHT - 1);

  pool_state_t           state;
  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [DATA_WIDTH-1:0] hold;

  logic                  start_map;
  logic                  accept;
  logic                  pair_done;
  logic                  lb_wr;
  logic                  lb_rd;
  logic [DATA_WIDTH-1:0] pair_max;
  logic [DATA_WIDTH-1:0] lb_head;
  logic [DATA_WIDTH-1:0] pool_max;
  logic [DATA_WIDTH-1:0] out_next;

  assign start_map = (state == IDLE) && start;
  assign accept    = (state == RUN) && in_valid;
  assign pair_done = accept && col[0];
  assign lb_wr     = pair_done && !row[0];
  assign lb_rd     = pair_done && row[0];

  assign pair_max = DATA_WIDTH'(signed_max(MAX_CALC_WIDTH'($signed(hold)),
                                           MAX_CALC_WIDTH'($signed(in_data))));
  assign pool_max = DATA_WIDTH'(signed_max(MAX_CALC_WIDTH'($signed(lb_head)),
                                           MAX_CALC_WIDTH'($signed(pair_max))));

`ifdef POOL_RELU_EN
  // ReLU after max pooling gives the same result as ReLU before it.
  assign out_next = pool_max[DATA_WIDTH-1] ? '0 : pool_max;
`else
  assign out_next = pool_max;
`endif

  pool_line_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IFM_WIDTH / 2),
    .ADD_WIDTH  (ADD_WIDTH)
  ) u_line_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start_map),
    .wr_en   (lb_wr),
    .wr_data (pair_max),
    .rd_en   (lb_rd),
    .rd_data (lb_head)
  );

  // Control FSM with raster counters; done is raised on the transition into
  // DONE so it coincides with the output of the final window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
      hold  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            col   <= '0;
            row   <= '0;
            hold  <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (in_valid) begin
            if (!col[0]) begin
              hold <= in_data;
            end
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                row   <= '0;
                state <= DONE;
                done  <= 1'b1;
              end else begin
                row <= row + ROW_W'(1);
              end
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output register: data is forced to 0 on every non-valid cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= lb_rd;
      out_data  <= lb_rd ? out_next : '0;
    end
  end

endmodule

// File: tb/tb_max_pool_2x2.sv
// ---------------------------------------------------------------------------
// tb_max_pool_2x2
// Directed bench for max_pool_2x2. Three instances (4x4, 2x2, 20x20) share
// one input stream; 'sel' picks which instance's outputs are observed.
// Honours POOL_RELU_EN when choosing expected values for negative windows.
// ---------------------------------------------------------------------------
module tb_max_pool_2x2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [15:0] in_data;

  logic        v4, b4, d4;
  logic [15:0] o4;
  logic        v2, b2, d2;
  logic [15:0] o2;
  logic        v20, b20, d20;
  logic [15:0] o20;

  int          sel;
  logic        obs_valid, obs_busy, obs_done;
  logic [15:0] obs_data;

  int vec_count   = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  max_pool_2x2 #(.DATA_WIDTH(16), .IFM_WIDTH(4), .IFM_HEIGHT(4), .ADD_WIDTH(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .out_valid(v4), .out_data(o4), .busy(b4), .done(d4));

  max_pool_2x2 #(.DATA_WIDTH(16), .IFM_WIDTH(2), .IFM_HEIGHT(2), .ADD_WIDTH(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .out_valid(v2), .out_data(o2), .busy(b2), .done(d2));

  max_pool_2x2 #(.DATA_WIDTH(16), .IFM_WIDTH(20), .IFM_HEIGHT(20), .ADD_WIDTH(4)) dut20 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .out_valid(v20), .out_data(o20), .busy(b20), .done(d20));

  always_comb begin
    obs_valid = v4;
    obs_data  = o4;
    obs_busy  = b4;
    obs_done  = d4;
    if (sel == 1) begin
      obs_valid = v2;
      obs_data  = o2;
      obs_busy  = b2;
      obs_done  = d2;
    end else if (sel == 2) begin
      obs_valid = v20;
      obs_data  = o20;
      obs_busy  = b20;
      obs_done  = d20;
    end
  end

  function automatic logic [15:0] relu(input logic [15:0] x);
`ifdef POOL_RELU_EN
    return x[15] ? 16'd0 : x;
`else
    return x;
`endif
  endfunction

  // Mode 0: 1..16 raster; 1: -5,-3,-7,-9; 2: all 7s;
  // 3: r*20+c+m with odd-parity positions negated.
  function automatic logic [15:0] pixelAt(input int mode, input int m, input int r, input int c);
    int base;
    case (mode)
      0: return 16'(r * 4 + c + 1);
      1: begin
        case (r * 2 + c)
          0: return 16'(-5);
          1: return 16'(-3);
          2: return 16'(-7);
          default: return 16'(-9);
        endcase
      end
      2: return 16'd7;
      default: begin
        base = r * 20 + c + m;
        return ((r + c) % 2 == 1) ? 16'(-base) : 16'(base);
      end
    endcase
  endfunction

  // Window maxima worked out per pattern: mode 0 is bottom-right 8i+2j+6,
  // mode 1 is -3, mode 2 is 7, mode 3 is the positive bottom-right entry.
  function automatic logic [15:0] expOut(input int mode, input int m, input int i, input int j);
    case (mode)
      0: return 16'(8 * i + 2 * j + 6);
      1: return relu(16'(-3));
      2: return 16'd7;
      default: return 16'((2 * i + 1) * 20 + 2 * j + 1 + m);
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vec_count++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
             tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge pass, and return 1 time unit
  // after it so registered outputs reflect this cycle.
  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic s);
    in_valid = v;
    in_data  = d;
    start    = s;
    @(posedge clk);
    #1;
  endtask

  task automatic resetAll();
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One full map: start pulse, every pixel (optional random gaps, optional
  // extra start on pixel start_at), then a start held during DONE.
  task automatic runMap(input int w, input int h, input int mode, input int m,
                        input bit gaps, input int start_at);
    int seen;
    bit last;
    seen = 0;
    applyStimulus(1'b0, 16'd0, 1'b1);
    checkOutput("start_busy", 16'(obs_busy), 16'd1);
    checkOutput("start_valid", 16'(obs_valid), 16'd0);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (gaps) begin
          for (int g = 0; g < 4 && $urandom_range(1, 0) == 1; g++) begin
            applyStimulus(1'b0, 16'($urandom), 1'b0);
            checkOutput("gap_valid", 16'(obs_valid), 16'd0);
            seen += int'(obs_valid);
          end
        end
        applyStimulus(1'b1, pixelAt(mode, m, r, c), 1'((r * w + c) == start_at));
        seen += int'(obs_valid);
        last = (r == h - 1) && (c == w - 1);
        if ((r % 2 == 1) && (c % 2 == 1)) begin
          checkOutput("pool_valid", 16'(obs_valid), 16'd1);
          checkOutput("pool_data", obs_data, expOut(mode, m, r / 2, c / 2));
        end else begin
          checkOutput("quiet_valid", 16'(obs_valid), 16'd0);
          checkOutput("quiet_data", obs_data, 16'd0);
        end
        checkOutput("done", 16'(obs_done), 16'(last));
        checkOutput("busy", 16'(obs_busy), 16'd1);
      end
    end
    checkOutput("out_count", 16'(seen), 16'(w * h / 4));
    applyStimulus(1'b0, 16'd0, 1'b1);
    checkOutput("post_busy", 16'(obs_busy), 16'd0);
    checkOutput("post_done", 16'(obs_done), 16'd0);
    checkOutput("post_valid", 16'(obs_valid), 16'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sel      = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #2;
    checkOutput("rst_valid4", 16'(v4), 16'd0);
    checkOutput("rst_data4", o4, 16'd0);
    checkOutput("rst_busy4", 16'(b4), 16'd0);
    checkOutput("rst_done4", 16'(d4), 16'd0);
    checkOutput("rst_valid2", 16'(v2), 16'd0);
    checkOutput("rst_valid20", 16'(v20), 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] 4x4 continuous 1..16");
    sel = 0;
    runMap(4, 4, 0, 0, 1'b0, -1);

    $display("[TB] 2x2 signed window");
    resetAll();
    sel = 1;
    runMap(2, 2, 1, 0, 1'b0, -1);

    $display("[TB] 4x4 with random in_valid gaps");
    resetAll();
    sel = 0;
    runMap(4, 4, 0, 0, 1'b1, -1);

    $display("[TB] in_valid before start, start during RUN");
    resetAll();
    sel = 0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 16'd500, 1'b0);
      checkOutput("pre_valid", 16'(obs_valid), 16'd0);
      checkOutput("pre_busy", 16'(obs_busy), 16'd0);
    end
    runMap(4, 4, 0, 0, 1'b0, 5);

    $display("[TB] reset mid-map then all-7s map");
    resetAll();
    sel = 0;
    applyStimulus(1'b0, 16'd0, 1'b1);
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b1, pixelAt(0, 0, k / 4, k % 4), 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 16'(obs_valid), 16'd0);
    checkOutput("midrst_data", obs_data, 16'd0);
    checkOutput("midrst_busy", 16'(obs_busy), 16'd0);
    checkOutput("midrst_done", 16'(obs_done), 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 16'd9, 1'b0);
      checkOutput("nostart_valid", 16'(obs_valid), 16'd0);
      checkOutput("nostart_busy", 16'(obs_busy), 16'd0);
    end
    runMap(4, 4, 2, 0, 1'b0, -1);

    $display("[TB] 20x20 back-to-back maps");
    resetAll();
    sel = 2;
    runMap(20, 20, 3, 0, 1'b0, -1);
    runMap(20, 20, 3, 1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
